sync_fpd: RTL and testbench

//  Sequential IEEE-754 floating-point divider: quotient = A / B. Inverse companion to the

---
 rtl/sync_fpd.sv | 251 +++++++++++++++++++++++++
 tb/tb_sync_fpd.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sync_fpd.sv
// Sequential IEEE-754 divider (A / B), restoring mantissa division at one quotient bit per clock.
// Define FPD_ROUND_NEAREST_EN for round-to-nearest-even; otherwise the result truncates toward zero.
module sync_fpd #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic                   isZeroA,
  input  logic [EXP_W+MAN_W:0]   B,
  input  logic                   isZeroB,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   quotient,
  output logic                   isZeroOut,
  output logic                   divByZero
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int QW = MAN_W + 3;
  localparam int RW = MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(QW);

  localparam logic signed [EW-1:0] BIAS  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] ONE   = EW'(1);
  localparam logic signed [EW-1:0] EZERO = '0;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [RW-1:0]           r_q, r_d;
  logic [RW-1:0]           mb_q, mb_d;
  logic [QW-1:0]           q_q, q_d;
  logic signed [EW-1:0]    e_q, e_d;
  logic                    sign_q, sign_d;
  logic                    spc_q, spc_d;
  logic [W-1:0]            spc_res_q, spc_res_d;
  logic                    spc_zero_q, spc_zero_d;
  logic                    spc_dbz_q, spc_dbz_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [W-1:0]            quot_q, quot_d;
  logic                    zero_q, zero_d;
  logic                    dbz_q, dbz_d;

`ifdef FPD_ROUND_NEAREST_EN
  function automatic logic [MAN_W:0] round_frac(input logic [MAN_W-1:0] f,
                                                input logic g, input logic s);
    return {1'b0, f} + (MAN_W+1)'(g & (s | f[0]));
  endfunction
`else
  function automatic logic [MAN_W:0] round_frac(input logic [MAN_W-1:0] f);
    return {1'b0, f};
  endfunction
`endif

  // Saturate the rounded exponent to signed infinity or signed zero; MSB of the return is isZero.
  function automatic logic [W:0] pack_result(input logic s, input logic signed [EW-1:0] e,
                                             input logic [MAN_W-1:0] f);
    if (e >= EMAX)
      return {1'b0, s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (e <= EZERO)
      return {1'b1, s, {(W-1){1'b0}}};
    else
      return {1'b0, s, e[EXP_W-1:0], f};
  endfunction

  // Operand classification; the zero flags override whatever bits are present.
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] man_a, man_b;
  logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, sign_in;

  assign exp_a   = A[W-2:MAN_W];
  assign exp_b   = B[W-2:MAN_W];
  assign man_a   = A[MAN_W-1:0];
  assign man_b   = B[MAN_W-1:0];
  assign sign_in = A[W-1] ^ B[W-1];
  assign zero_a  = isZeroA | (exp_a == '0);
  assign zero_b  = isZeroB | (exp_b == '0);
  assign inf_a   = !zero_a & (&exp_a) & (man_a == '0);
  assign inf_b   = !zero_b & (&exp_b) & (man_b == '0);
  assign nan_a   = !zero_a & (&exp_a) & (man_a != '0);
  assign nan_b   = !zero_b & (&exp_b) & (man_b != '0);

  logic         spc_in, spc_zero_in, spc_dbz_in;
  logic [W-1:0] spc_res_in;

  always_comb begin
    spc_in      = 1'b1;
    spc_res_in  = '0;
    spc_zero_in = 1'b0;
    spc_dbz_in  = 1'b0;
    if (nan_a | nan_b | (zero_a & zero_b) | (inf_a & inf_b)) begin
      spc_res_in = QNAN;
    end else if (inf_a) begin
      spc_res_in = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (inf_b | zero_a) begin
      spc_res_in  = {sign_in, {(W-1){1'b0}}};
      spc_zero_in = 1'b1;
    end else if (zero_b) begin
      spc_res_in = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spc_dbz_in = 1'b1;
    end else begin
      spc_in = 1'b0;
    end
  end

  // Normalisation: a leading 0 in q means the quotient mantissa was below 1.0.
  logic [MAN_W-1:0]     frac_n;
  logic signed [EW-1:0] e_n, e_r;
  logic [MAN_W:0]       rnd_n;
  logic [W:0]           packed_n;
`ifdef FPD_ROUND_NEAREST_EN
  logic                 guard_n, sticky_n;
`endif

  always_comb begin
    if (q_q[QW-1]) begin
      frac_n = q_q[QW-2:2];
      e_n    = e_q;
    end else begin
      frac_n = q_q[QW-3:1];
      e_n    = e_q - ONE;
    end
`ifdef FPD_ROUND_NEAREST_EN
    guard_n  = q_q[QW-1] ? q_q[1] : q_q[0];
    sticky_n = (q_q[QW-1] & q_q[0]) | (|r_q);
    rnd_n    = round_frac(frac_n, guard_n, sticky_n);
`else
    rnd_n    = round_frac(frac_n);
`endif
    e_r      = e_n + $signed({{(EW-1){1'b0}}, rnd_n[MAN_W]});
    packed_n = pack_result(sign_q, e_r, rnd_n[MAN_W-1:0]);
  end

  logic          qbit;
  logic [RW-1:0] r_sub;

  assign qbit  = (r_q >= mb_q);
  assign r_sub = qbit ? (r_q - mb_q) : r_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    r_d        = r_q;
    mb_d       = mb_q;
    q_d        = q_q;
    e_d        = e_q;
    sign_d     = sign_q;
    spc_d      = spc_q;
    spc_res_d  = spc_res_q;
    spc_zero_d = spc_zero_q;
    spc_dbz_d  = spc_dbz_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    quot_d     = quot_q;
    zero_d     = zero_q;
    dbz_d      = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !busy_q) begin
          state_d    = S_DIV;
          busy_d     = 1'b1;
          cnt_d      = '0;
          r_d        = {1'b0, 1'b1, man_a};
          mb_d       = {1'b0, 1'b1, man_b};
          q_d        = '0;
          e_d        = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + BIAS;
          sign_d     = sign_in;
          spc_d      = spc_in;
          spc_res_d  = spc_res_in;
          spc_zero_d = spc_zero_in;
          spc_dbz_d  = spc_dbz_in;
        end
      end
      S_DIV: begin
        r_d   = r_sub << 1;
        q_d   = {q_q[QW-2:0], qbit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(QW - 1))
          state_d = S_NORM;
      end
      S_NORM: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (spc_q) begin
          quot_d = spc_res_q;
          zero_d = spc_zero_q;
          dbz_d  = spc_dbz_q;
        end else begin
          quot_d = packed_n[W-1:0];
          zero_d = packed_n[W];
          dbz_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      r_q        <= '0;
      mb_q       <= '0;
      q_q        <= '0;
      e_q        <= '0;
      sign_q     <= 1'b0;
      spc_q      <= 1'b0;
      spc_res_q  <= '0;
      spc_zero_q <= 1'b0;
      spc_dbz_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      quot_q     <= '0;
      zero_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r_q        <= r_d;
      mb_q       <= mb_d;
      q_q        <= q_d;
      e_q        <= e_d;
      sign_q     <= sign_d;
      spc_q      <= spc_d;
      spc_res_q  <= spc_res_d;
      spc_zero_q <= spc_zero_d;
      spc_dbz_q  <= spc_dbz_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      quot_q     <= quot_d;
      zero_q     <= zero_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign isZeroOut = zero_q;
  assign divByZero = dbz_q;

endmodule

// File: tb/tb_sync_fpd.sv
// Scoreboard bench for sync_fpd (binary32): directed operands, expected results queued at accept.
module tb_sync_fpd;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        isZeroA = 1'b0;
  logic        isZeroB = 1'b0;
  logic        busy, done, isZeroOut, divByZero;
  logic [31:0] quotient;

  sync_fpd #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A(A), .isZeroA(isZeroA), .B(B), .isZeroB(isZeroB),
    .busy(busy), .done(done), .quotient(quotient),
    .isZeroOut(isZeroOut), .divByZero(divByZero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic        z;
    logic        d;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   nchk = 0;
  int   npass = 0;
  int   ndone = 0;
  int   nexp = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act === req) npass++;
    else $display("FAIL %s: got %h, want %h", name, act, req);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      ndone++;
      if (sb.size() == 0) begin
        chk("stray_done", {31'b0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("isZeroOut", {31'b0, isZeroOut}, {31'b0, e.z});
        chk("divByZero", {31'b0, divByZero}, {31'b0, e.d});
        chk("latency", cyc - e.acc, 32'd27);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic za,
                       input logic zb, input logic [31:0] eq, input logic ez,
                       input logic ed, input bit push);
    exp_t e;
    A = a; B = b; isZeroA = za; isZeroB = zb; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.q = eq; e.z = ez; e.d = ed; e.acc = cyc;
      sb.push_back(e);
      nexp++;
    end
  endtask

  task automatic wait_done();
    int n0;
    n0 = ndone;
    for (int i = 0; i < 60; i++) begin
      if (ndone != n0) break;
      @(posedge clk);
    end
    chk("done_seen", {31'b0, ndone != n0}, 32'd1);
    #1;
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic za,
                     input logic zb, input logic [31:0] eq, input logic ez, input logic ed);
    issue(a, b, za, zb, eq, ez, ed, 1'b1);
    wait_done();
  endtask

  logic [31:0] third_q;

  initial begin
`ifdef FPD_ROUND_NEAREST_EN
    third_q = 32'h3EAAAAAB;
`else
    third_q = 32'h3EAAAAAA;
`endif
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_isZeroOut", {31'b0, isZeroOut}, 32'd0);
    chk("rst_divByZero", {31'b0, divByZero}, 32'd0);

    run(32'h40C00000, 32'h40000000, 0, 0, 32'h40400000, 0, 0);   // 6 / 2
    run(32'h3F800000, 32'h40400000, 0, 0, third_q,       0, 0);   // 1 / 3
    run(32'hC0F00000, 32'h40200000, 0, 0, 32'hC0400000, 0, 0);   // -7.5 / 2.5
    run(32'hC0F00000, 32'h40200000, 0, 1, 32'hFF800000, 0, 1);   // -7.5 / 0
    run(32'h7F000000, 32'h00800000, 0, 0, 32'h7F800000, 0, 0);   // overflow
    run(32'h00800000, 32'h7F000000, 0, 0, 32'h00000000, 1, 0);   // underflow
    run(32'h40C00000, 32'h40000000, 1, 1, 32'h7FC00000, 0, 0);   // 0 / 0
    run(32'h7F800001, 32'h40000000, 0, 0, 32'h7FC00000, 0, 0);   // NaN input
    run(32'h7F800000, 32'hC0000000, 0, 0, 32'hFF800000, 0, 0);   // inf / -2
    run(32'h40000000, 32'hFF800000, 0, 0, 32'h80000000, 1, 0);   // 2 / -inf
    run(32'h00400000, 32'hC0000000, 0, 0, 32'h80000000, 1, 0);   // subnormal / -2
    run(32'h7F800000, 32'h7F800000, 0, 0, 32'h7FC00000, 0, 0);   // inf / inf

    // A start while busy must be ignored and leave the first operation intact.
    issue(32'h41200000, 32'h40A00000, 0, 0, 32'h40000000, 0, 0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("busy_mid", {31'b0, busy}, 32'd1);
    A = 32'h3F800000; B = 32'h40400000; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    repeat (35) @(posedge clk);
    #1;

    // Reset in the middle of a division aborts it without a done pulse.
    issue(32'h40C00000, 32'h40000000, 0, 0, 32'h0, 0, 0, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_isZeroOut", {31'b0, isZeroOut}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (35) @(posedge clk);
    #1;
    run(32'hC1100000, 32'h40400000, 0, 0, 32'hC0400000, 0, 0);   // -9 / 3 after reset

    repeat (5) @(posedge clk);
    #1;
    chk("done_count", ndone, nexp);
    chk("queue_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
